// File: rtl/scr1_mem_arbiter_if.sv
// Memory request/response bundle shared by both masters and the downstream slave.
// No latency of its own; it is only a set of wires grouped by direction.
// Backpressure: the request side is held stable until req_ack, and resp==NOTRDY stalls the data phase.
package scr1_mem_arbiter_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

interface scr1_mem_arbiter_if;
  import scr1_mem_arbiter_pkg::*;

  logic                              req;
  logic                              req_ack;
  type_scr1_mem_cmd_e                cmd;
  type_scr1_mem_width_e              width;
  logic [SCR1_DMEM_AWIDTH-1:0]       addr;
  logic [SCR1_DMEM_DWIDTH-1:0]       wdata;
  logic [SCR1_DMEM_DWIDTH-1:0]       rdata;
  type_scr1_mem_resp_e               resp;

  // Side that issues requests and consumes responses.
  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  // Side that accepts requests and produces responses.
  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );

endinterface

// File: rtl/scr1_mem_arbiter.sv
// Two-master arbiter onto one SCR1 memory slave port, single outstanding transfer with owner tracking.
// Latency: zero added cycles on the request path (combinational mux), responses routed combinationally.
// Backpressure: a stalled slave request locks the grant; a new accept only in IDLE or an RDY_OK data cycle.
module scr1_mem_arbiter #(
  parameter bit          SCR1_ARB_RR      = 1'b1,
  parameter int unsigned SCR1_ARB_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  scr1_mem_arbiter_if.slave  m0_if,
  scr1_mem_arbiter_if.slave  m1_if,
  scr1_mem_arbiter_if.master slv_if
);
  import scr1_mem_arbiter_pkg::*;

  localparam int unsigned TW           = (SCR1_ARB_TIMEOUT > 0) ? $clog2(SCR1_ARB_TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST_INT = (SCR1_ARB_TIMEOUT > 0) ? SCR1_ARB_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_LAST_INT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } arb_state_e;

  arb_state_e          fsm_q, fsm_d;
  logic                owner_q, owner_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic                lock_gnt_q, lock_gnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic                gnt;
  logic                gnt_sel;
  logic                win;
  logic                slv_req;
  logic                accept;
  logic                tmo_expire;
  type_scr1_mem_resp_e ores;

  // Watchdog fires on the last allowed NOTRDY cycle of a data phase; the slave response is only
  // looked at while a transfer is outstanding, anything it drives in IDLE is treated as NOTRDY.
  always_comb begin
    tmo_expire = 1'b0;
    ores       = SCR1_MEM_RESP_NOTRDY;
    if (fsm_q == ST_DATA) begin
      tmo_expire = (SCR1_ARB_TIMEOUT != 0) && (slv_if.resp == SCR1_MEM_RESP_NOTRDY) &&
                   (tmo_cnt_q == TMO_LAST);
      ores       = tmo_expire ? SCR1_MEM_RESP_RDY_ER : slv_if.resp;
    end
  end

  // Grant selection: a held (locked) grant wins, otherwise lone requester, otherwise priority/RR.
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = lock_gnt_q;
    end else if (m0_if.req && m1_if.req) begin
      gnt = SCR1_ARB_RR ? rr_ptr_q : 1'b0;
    end else begin
      gnt = m1_if.req;
    end
    // During reset the slave-side fields follow m0.
    gnt_sel = rst_n & gnt;
  end

  // Request path towards the slave and per-master acknowledges; everything is masked while in reset.
  always_comb begin
    win    = (fsm_q == ST_IDLE) || (ores == SCR1_MEM_RESP_RDY_OK);
    slv_req = rst_n & win & (m0_if.req | m1_if.req);
    accept  = slv_req & slv_if.req_ack;

    slv_if.req   = slv_req;
    slv_if.cmd   = gnt_sel ? m1_if.cmd   : m0_if.cmd;
    slv_if.width = gnt_sel ? m1_if.width : m0_if.width;
    slv_if.addr  = gnt_sel ? m1_if.addr  : m0_if.addr;
    slv_if.wdata = gnt_sel ? m1_if.wdata : m0_if.wdata;

    m0_if.req_ack = accept & ~gnt;
    m1_if.req_ack = accept &  gnt;
  end

  // Response routing: only the owner of the outstanding transfer sees the slave response.
  always_comb begin
    m0_if.rdata = slv_if.rdata;
    m1_if.rdata = slv_if.rdata;
    m0_if.resp  = SCR1_MEM_RESP_NOTRDY;
    m1_if.resp  = SCR1_MEM_RESP_NOTRDY;
    if (rst_n && (fsm_q == ST_DATA)) begin
      if (owner_q) begin
        m1_if.resp = ores;
      end else begin
        m0_if.resp = ores;
      end
    end
  end

  // Next-state: data-phase tracking, ownership handover, RR pointer, grant lock and watchdog count.
  always_comb begin
    fsm_d      = fsm_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_gnt_d = lock_gnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          fsm_d = ST_DATA;
        end
      end
      ST_DATA: begin
        case (ores)
          SCR1_MEM_RESP_RDY_OK: fsm_d = accept ? ST_DATA : ST_IDLE;
          SCR1_MEM_RESP_NOTRDY: tmo_cnt_d = tmo_cnt_q + TW'(1);
          default:              fsm_d = ST_IDLE;
        endcase
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (accept) begin
      owner_d   = gnt;
      rr_ptr_d  = ~gnt;
      tmo_cnt_d = '0;
      lock_d    = 1'b0;
    end else if (slv_req) begin
      // Slave saw a request it did not take: keep presenting the same master until it does.
      lock_d     = 1'b1;
      lock_gnt_d = gnt;
    end
  end

  // State registers, cleared asynchronously so a transfer in flight is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      lock_q     <= 1'b0;
      lock_gnt_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_gnt_q <= lock_gnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule
